pe_host_bram: RTL and testbench

- Host-side counterpart of the PE array's BRAM master port.
- Owns the shared word memory and loads operands from an input stream.
- Pulses `pe_start`, then serves the PE array's BRAM reads and writes until `pe_done`.
- Streams the result region back out.
- Sits between the system data path and `pearray_my`; replaces the bench-only memory model with synthesizable RTL.

---
 rtl/pe_host_bram.sv | 154 +++++++++++++++
 tb/tb_pe_host_bram.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/pe_host_bram.sv
// Host-side word memory for the PE array: loads operands from a stream, starts the PE,
// serves its BRAM port, then streams the result region out. Optional macro: PE_HOST_TIMEOUT_EN.
module pe_host_bram #(
  parameter int DATA_W         = 8,
  parameter int DEPTH          = 72,
  parameter int AW             = 7,
  parameter int LOAD_WORDS     = 72,
  parameter int RESULT_BASE    = 64,
  parameter int RESULT_WORDS   = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESETN,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              pe_start,
  input  logic              pe_done,
  input  logic [31:0]       BRAM_ADDR,
  input  logic [DATA_W-1:0] BRAM_WRDATA,
  input  logic [3:0]        BRAM_WE,
  output logic [DATA_W-1:0] BRAM_RDDATA,
  output logic              busy,
  output logic              err,
  output logic              timeout
);

  localparam int LANES = (DATA_W / 8 < 4) ? DATA_W / 8 : 4;
  localparam int RW    = $clog2(RESULT_WORDS + 1);

  typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     load_ptr;
  logic [RW-1:0]     rd_ptr;
  logic [29:0]       word_addr;
  logic [AW-1:0]     word_idx;
  logic [AW-1:0]     drain_addr;
  logic              oor;
  logic              accept;
  logic              unused_bits;

  assign word_addr   = BRAM_ADDR[31:2];
  assign word_idx    = word_addr[AW-1:0];
  assign oor         = (word_addr >= 30'(DEPTH));
  assign s_ready     = S_AXI_ARESETN && (state == LOAD);
  assign accept      = s_valid && s_ready;
  assign drain_addr  = AW'(RESULT_BASE) + AW'(rd_ptr);
  assign unused_bits = ^{BRAM_ADDR[1:0], BRAM_WE};

  // Memory array is deliberately unreset so contents survive a reset
  always_ff @(posedge S_AXI_ACLK) begin
    if (accept) begin
      mem[load_ptr] <= s_data;
    end else if (state == RUN && !oor) begin
      for (int k = 0; k < LANES; k++) begin
        if (BRAM_WE[k]) mem[word_idx][8*k +: 8] <= BRAM_WRDATA[8*k +: 8];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) BRAM_RDDATA <= '0;
    else                BRAM_RDDATA <= oor ? '0 : mem[word_idx];
  end

`ifdef PE_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state    <= LOAD;
      load_ptr <= '0;
      rd_ptr   <= '0;
      pe_start <= 1'b0;
      busy     <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
      err      <= 1'b0;
`ifdef PE_HOST_TIMEOUT_EN
      timeout  <= 1'b0;
      tmo_cnt  <= '0;
`endif
    end else begin
      if (state == RUN && oor) err <= 1'b1;
      case (state)
        LOAD: begin
          if (accept) begin
            load_ptr <= load_ptr + 1'b1;
            if (load_ptr == AW'(LOAD_WORDS - 1)) begin
              state    <= START;
              pe_start <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        START: begin
          pe_start <= 1'b0;
          state    <= RUN;
`ifdef PE_HOST_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
        end
        RUN: begin
          if (pe_done) begin
            state  <= DRAIN;
            rd_ptr <= '0;
          end
`ifdef PE_HOST_TIMEOUT_EN
          else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout <= 1'b1;
            state   <= DRAIN;
            rd_ptr  <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DRAIN: begin
          // Output register refills whenever it is empty or being consumed
          if (!m_valid || m_ready) begin
            if (m_valid && m_last) begin
              state    <= LOAD;
              m_valid  <= 1'b0;
              m_last   <= 1'b0;
              busy     <= 1'b0;
              load_ptr <= '0;
            end else if (rd_ptr != RW'(RESULT_WORDS)) begin
              m_data  <= mem[drain_addr];
              m_valid <= 1'b1;
              m_last  <= (rd_ptr == RW'(RESULT_WORDS - 1));
              rd_ptr  <= rd_ptr + 1'b1;
            end else begin
              m_valid <= 1'b0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_host_bram.sv
// Directed self-checking bench for pe_host_bram: load, PE reads/writes, drain with
// backpressure, out-of-range access and mid-drain reset.
module tb_pe_host_bram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        m_valid, m_ready, m_last;
  logic [7:0]  m_data;
  logic        pe_start, pe_done;
  logic [31:0] BRAM_ADDR;
  logic [7:0]  BRAM_WRDATA, BRAM_RDDATA;
  logic [3:0]  BRAM_WE;
  logic        busy, err, timeout;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] model [72];
  logic [7:0] rd_q [$];
  logic [7:0] m_q [$];
  logic       done;
  int         popped, stall;

  always #5 clk = ~clk;

  pe_host_bram dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .pe_start     (pe_start),
    .pe_done      (pe_done),
    .BRAM_ADDR    (BRAM_ADDR),
    .BRAM_WRDATA  (BRAM_WRDATA),
    .BRAM_WE      (BRAM_WE),
    .BRAM_RDDATA  (BRAM_RDDATA),
    .busy         (busy),
    .err          (err),
    .timeout      (timeout)
  );

  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic bramRead(input logic [31:0] addr, input string tag);
    BRAM_ADDR = addr;
    BRAM_WE   = 4'h0;
    rd_q.push_back((addr[31:2] < 30'd72) ? model[addr[8:2]] : 8'h00);
    applyStimulus(1);
    checkOutput(tag, 32'(BRAM_RDDATA), 32'(rd_q.pop_front()));
  endtask

  initial begin
    s_valid = 0; s_data = 0; m_ready = 0; pe_done = 0;
    BRAM_ADDR = 0; BRAM_WRDATA = 0; BRAM_WE = 0;

    applyStimulus(2);
    checkOutput("rst_s_ready", 32'(s_ready), 0);
    checkOutput("rst_pe_start", 32'(pe_start), 0);
    checkOutput("rst_m_valid", 32'(m_valid), 0);
    checkOutput("rst_m_last", 32'(m_last), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_timeout", 32'(timeout), 0);
    checkOutput("rst_rddata", 32'(BRAM_RDDATA), 0);
    rst_n = 1'b1;
    #1;
    checkOutput("release_s_ready", 32'(s_ready), 1);

    // First job: 72 words 0x00..0x47 back to back
    for (int i = 0; i < 72; i++) begin
      applyStimulus(1);
      s_valid  = 1'b1;
      s_data   = 8'(i);
      model[i] = 8'(i);
      checkOutput("load_s_ready", 32'(s_ready), 1);
    end
    applyStimulus(1);
    s_data = 8'hEE;
    checkOutput("after_load_s_ready", 32'(s_ready), 0);
    checkOutput("pe_start_high", 32'(pe_start), 1);
    checkOutput("start_busy", 32'(busy), 1);
    applyStimulus(1);
    s_valid = 1'b0;
    checkOutput("pe_start_low", 32'(pe_start), 0);
    checkOutput("run_busy", 32'(busy), 1);
    checkOutput("run_s_ready", 32'(s_ready), 0);

    bramRead(32'h10, "rd_0x10");
    bramRead(32'h11C, "rd_0x11C");
    bramRead(32'h0, "rd_word0");
    checkOutput("err_clear", 32'(err), 0);

    // Out-of-range write: word 128 aliases word 0 in the low address bits
    BRAM_ADDR = 32'h200; BRAM_WE = 4'hF; BRAM_WRDATA = 8'h5A;
    rd_q.push_back(8'h00);
    applyStimulus(1);
    checkOutput("rd_oor", 32'(BRAM_RDDATA), 32'(rd_q.pop_front()));
    checkOutput("err_set", 32'(err), 1);
    bramRead(32'h0, "no_alias_word0");

    BRAM_ADDR = 32'h100; BRAM_WE = 4'b0001; BRAM_WRDATA = 8'hA5;
    rd_q.push_back(model[64]);
    applyStimulus(1);
    checkOutput("rd_during_wr", 32'(BRAM_RDDATA), 32'(rd_q.pop_front()));
    model[64] = 8'hA5;
    BRAM_ADDR = 32'h104; BRAM_WE = 4'b1110; BRAM_WRDATA = 8'h77;
    rd_q.push_back(model[65]);
    applyStimulus(1);
    checkOutput("rd_lane_masked", 32'(BRAM_RDDATA), 32'(rd_q.pop_front()));
    bramRead(32'h100, "rd_written");
    bramRead(32'h104, "rd_unwritten_lane");

    BRAM_ADDR = 32'h0;
    m_ready = 1'b1;
    pe_done = 1'b1;
    applyStimulus(1);
    pe_done = 1'b0;
    checkOutput("drain_enter_m_valid", 32'(m_valid), 0);
    checkOutput("drain_busy", 32'(busy), 1);
    for (int i = 64; i < 72; i++) m_q.push_back(model[i]);
    applyStimulus(1);
    checkOutput("first_m_valid", 32'(m_valid), 1);

    // Drain with a 5-cycle stall on the third word
    done = 1'b0; popped = 0; stall = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (m_valid) begin
        checkOutput("m_data", 32'(m_data), 32'(m_q[0]));
        if (popped == 2 && stall < 5) begin
          m_ready = 1'b0;
          stall++;
        end else begin
          m_ready = 1'b1;
        end
        if (m_ready) begin
          void'(m_q.pop_front());
          popped++;
          checkOutput("m_last", 32'(m_last), 32'(m_q.size() == 0));
          if (m_q.size() == 0) done = 1'b1;
        end
      end else begin
        checkOutput("m_valid_gap", 32'(m_valid), 1);
      end
      applyStimulus(1);
    end
    checkOutput("drain_complete", 32'(done), 1);
    checkOutput("stall_cycles", 32'(stall), 5);
    checkOutput("back_to_load_s_ready", 32'(s_ready), 1);
    checkOutput("back_to_load_m_valid", 32'(m_valid), 0);
    checkOutput("back_to_load_busy", 32'(busy), 0);
    checkOutput("err_sticky", 32'(err), 1);
    checkOutput("timeout_idle", 32'(timeout), 0);
    m_ready = 1'b0;

    // Second job with gapped s_valid; pe_done pulsed in LOAD must be ignored
    pe_done = 1'b1;
    for (int i = 0; i < 72; i++) begin
      s_valid = 1'b0;
      applyStimulus(1);
      if (i == 0) checkOutput("pe_done_ignored", 32'(busy), 0);
      pe_done  = 1'b0;
      s_valid  = 1'b1;
      s_data   = 8'(8'h80 + i);
      model[i] = 8'(8'h80 + i);
      applyStimulus(1);
    end
    s_valid = 1'b0;
    checkOutput("job2_pe_start", 32'(pe_start), 1);
    applyStimulus(1);
    bramRead(32'h0, "job2_word0");
    pe_done = 1'b1;
    applyStimulus(1);
    pe_done = 1'b0;
    BRAM_ADDR = 32'h11C; BRAM_WE = 4'h1; BRAM_WRDATA = 8'h99;
    applyStimulus(1);
    checkOutput("job2_m_valid", 32'(m_valid), 1);
    checkOutput("job2_m_data", 32'(m_data), 32'(model[64]));

    // Asynchronous reset in the middle of DRAIN
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_m_valid", 32'(m_valid), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_err", 32'(err), 0);
    checkOutput("midrst_m_last", 32'(m_last), 0);
    checkOutput("midrst_s_ready", 32'(s_ready), 0);
    BRAM_WE = 4'h0;
    applyStimulus(1);
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_release_s_ready", 32'(s_ready), 1);
    applyStimulus(1);
    bramRead(32'h11C, "drain_write_dropped");
    bramRead(32'h0, "mem_survives_reset");
    bramRead(32'h104, "mem_survives_reset_65");
    checkOutput("err_after_reset", 32'(err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
